// File: rtl/alu_seq_pkg.sv
// Purpose : shared op codes, slice select codes, FSM encoding and op decode for alu_nibble_seq.
// Latency : n/a (package).
// Backpressure: n/a (package).
package alu_seq_pkg;

    // MIPS ALU control codes presented on the op port
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Slice function select; SEL_NONE makes the slice output zero (unsupported ops)
    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        SLT_FIX = 2'b10,
        DONE    = 2'b11
    } state_t;

    // Per-operation slice control, latched once at the request handshake
    typedef struct packed {
        logic [1:0] sel;    // slice function
        logic       binv;   // invert B and seed carry with 1 (subtract)
        logic       arith;  // ADD/SUB: carry_out and overflow are reported
        logic       slt;    // needs the SLT_FIX pass
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [2:0] op);
        ctrl_t c;
        c = '{sel: SEL_NONE, binv: 1'b0, arith: 1'b0, slt: 1'b0};
        case (op)
            OP_AND: c.sel = SEL_AND;
            OP_OR:  c.sel = SEL_OR;
            OP_ADD: begin c.sel = SEL_ADD; c.arith = 1'b1; end
            OP_SUB: begin c.sel = SEL_ADD; c.binv = 1'b1; c.arith = 1'b1; end
            OP_SLT: begin c.sel = SEL_ADD; c.binv = 1'b1; c.slt = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nibble_alu.sv
// Purpose : combinational 4-bit MIPS ALU slice (AND / OR / ADD with optional B inversion).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; sequencing is owned by the caller.
// Ports   : a, b (4-bit operands), cin (carry in), binv (invert b), sel1/sel0 (function),
//           result (4-bit), co (carry out of the adder).
module nibble_alu
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       binv,
    input  logic       sel1,
    input  logic       sel0,
    output logic [3:0] result,
    output logic       co
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    assign b_eff = b ^ {4{binv}};
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0, cin};
    assign co    = sum[4];

    always_comb begin
        result = 4'b0;
        case ({sel1, sel0})
            SEL_AND: result = a & b_eff;
            SEL_OR:  result = a | b_eff;
            SEL_ADD: result = sum[3:0];
            default: result = 4'b0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Purpose : WIDTH-bit MIPS ALU executed one nibble per clock on a single 4-bit slice.
// Latency : out_valid NIB+1 edges after the request handshake (NIB+2 for SLT).
// Backpressure: result/flags held in DONE until out_ready; no new request accepted until then.
// Ports   : clk, rst_n; request in_valid/in_ready with op, a, b;
//           response out_valid/out_ready with result, zero, carry_out, overflow.
module alu_nibble_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);
    import alu_seq_pkg::*;

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t           state, state_nxt;
    ctrl_t            ctrl;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry, a_msb, b_msb;
    logic [3:0]       slice_res;
    logic             slice_co;
    logic             handshake;
    logic             beff, sum_msb, ovf_raw, slt_bit;

    assign handshake = in_valid & in_ready;

    nibble_alu u_slice (
        .a      (a_sh[3:0]),
        .b      (b_sh[3:0]),
        .cin    (carry),
        .binv   (ctrl.binv),
        .sel1   (ctrl.sel[1]),
        .sel0   (ctrl.sel[0]),
        .result (slice_res),
        .co     (slice_co)
    );

    // Final flags come from the captured operand MSBs and the MSB of the
    // assembled sum, so no full-width adder is needed.
    assign beff    = b_msb ^ ctrl.binv;
    assign sum_msb = res_sh[WIDTH-1];
    assign ovf_raw = (a_msb == beff) & (sum_msb != a_msb);
    assign slt_bit = sum_msb ^ ovf_raw;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = ctrl.slt ? SLT_FIX : DONE;
            SLT_FIX: state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            ctrl      <= '0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (handshake) begin
                        ctrl   <= decode_op(op);
                        carry  <= decode_op(op).binv;
                        a_sh   <= a;
                        b_sh   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // Slice output enters at the top; after NIB passes the
                    // first nibble has reached bit 0.
                    res_sh <= {slice_res, res_sh[WIDTH-1:4]};
                    a_sh   <= {4'b0, a_sh[WIDTH-1:4]};
                    b_sh   <= {4'b0, b_sh[WIDTH-1:4]};
                    carry  <= slice_co;
                    cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                SLT_FIX: begin
                    res_sh <= {{(WIDTH-1){1'b0}}, slt_bit};
                end
                DONE: begin
                    // First DONE cycle publishes the registered result and
                    // flags; afterwards they are held until consumed.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= res_sh;
                        zero      <= (res_sh == '0);
                        carry_out <= ctrl.arith & carry;
                        overflow  <= ctrl.arith & ovf_raw;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
